// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch stall controller and its watchdog.
// Latency: none, declarations only. Backpressure: none.
package fetch_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    MISS = 1'b1
  } fetch_state_e;

  // Instruction the IF/ID register takes in place of the fetched word on a flush.
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/fetch_watchdog.sv
// Refill watchdog: counts MISS cycles, fires when TIMEOUT passes without a refill, keeps a sticky flag.
// Latency: expire is combinational and timeout_flag is registered. Backpressure: none.
module fetch_watchdog #(
  parameter int TIMEOUT  = 64,
  parameter int TO_WIDTH = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic run,
  input  logic done,
  output logic expire,
  output logic timeout_flag
);

  logic [TO_WIDTH-1:0] count_q, count_d;
  logic                flag_q, flag_d;

  // While in MISS, count_q is the number of MISS cycles already elapsed. A refill arriving in the last allowed cycle still wins.
  always_comb begin
    expire  = run && !done && (count_q == TO_WIDTH'(TIMEOUT - 1));
    count_d = count_q;
    if (start) begin
      count_d = '0;
    end else if (run) begin
      count_d = count_q + TO_WIDTH'(1);
    end
    flag_d = flag_q | expire;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
    end
  end

  assign timeout_flag = flag_q;

endmodule

// File: rtl/fetch_stall_controller.sv
// IF stage sequencer that drives PC and IF/ID enables, the flush, and the I-cache refill FSM. Optional counters are enabled by FETCH_PERF_CNT_EN.
// Latency: outputs are combinational from the state and the inputs, and a miss costs at least 2 cycles. Backpressure: memRead is held until memReady arrives or the watchdog fires.
module fetch_stall_controller
  import fetch_ctrl_pkg::*;
#(
  parameter int TIMEOUT  = 64,
  parameter int TO_WIDTH = 7
`ifdef FETCH_PERF_CNT_EN
  ,
  parameter int CNT_WIDTH = 32
`endif
) (
  input  logic Clk,
  input  logic Reset,
  input  logic hit,
  input  logic memReady,
  input  logic loadUseHazard,
  input  logic branchTaken,
  output logic pcWrite,
  output logic ifidWrite,
  output logic ifidFlush,
  output logic memRead,
  output logic missTimeout,
  output logic inMiss
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] missCount,
  output logic [CNT_WIDTH-1:0] stallCycles
`endif
);

  fetch_state_e state_q, state_d;
  logic         wd_start, wd_run, wd_expire;

  always_comb begin
    state_d   = state_q;
    pcWrite   = 1'b0;
    ifidWrite = 1'b0;
    ifidFlush = 1'b0;
    memRead   = 1'b0;
    inMiss    = 1'b0;
    wd_start  = 1'b0;
    wd_run    = 1'b0;

    if (Reset) begin
      ifidWrite = 1'b1;
      ifidFlush = 1'b1;
      state_d   = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (branchTaken) begin
            pcWrite   = 1'b1;
            ifidWrite = 1'b1;
            ifidFlush = 1'b1;
          end else if (!hit) begin
            memRead   = 1'b1;
            ifidFlush = 1'b1;
            ifidWrite = !loadUseHazard;
            wd_start  = 1'b1;
            state_d   = MISS;
          end else if (!loadUseHazard) begin
            pcWrite   = 1'b1;
            ifidWrite = 1'b1;
          end
        end
        MISS: begin
          // A redirect loads the target PC here, but the refill in flight continues.
          memRead   = 1'b1;
          inMiss    = 1'b1;
          ifidFlush = 1'b1;
          ifidWrite = !loadUseHazard;
          pcWrite   = branchTaken;
          wd_run    = 1'b1;
          if (memReady || wd_expire) begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  fetch_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_WIDTH(TO_WIDTH)
  ) u_watchdog (
    .clk         (Clk),
    .reset       (Reset),
    .start       (wd_start),
    .run         (wd_run),
    .done        (memReady),
    .expire      (wd_expire),
    .timeout_flag(missTimeout)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] miss_count_q, miss_count_d;
  logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;

  // Both counters saturate so that a long run never wraps back to a small value.
  always_comb begin
    miss_count_d   = miss_count_q;
    stall_cycles_d = stall_cycles_q;
    if (state_q == RUN && state_d == MISS && !(&miss_count_q)) begin
      miss_count_d = miss_count_q + CNT_WIDTH'(1);
    end
    if (!pcWrite && !Reset && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      miss_count_q   <= '0;
      stall_cycles_q <= '0;
    end else begin
      miss_count_q   <= miss_count_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign missCount   = miss_count_q;
  assign stallCycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_fetch_stall_controller.sv
// Directed bench for fetch_stall_controller. The observed vector is {pcWrite, ifidWrite, ifidFlush, memRead, inMiss, missTimeout}.
module tb_fetch_stall_controller;

  logic Clk = 1'b0;
  logic Reset, hit, memReady, loadUseHazard, branchTaken;
  logic pcWrite, ifidWrite, ifidFlush, memRead, missTimeout, inMiss;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] missCount, stallCycles;
`endif

  int passed = 0;
  int total  = 0;

  always #5 Clk = ~Clk;

  wire [5:0] obs = {pcWrite, ifidWrite, ifidFlush, memRead, inMiss, missTimeout};

  fetch_stall_controller #(
    .TIMEOUT (4),
    .TO_WIDTH(7)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .hit          (hit),
    .memReady     (memReady),
    .loadUseHazard(loadUseHazard),
    .branchTaken  (branchTaken),
    .pcWrite      (pcWrite),
    .ifidWrite    (ifidWrite),
    .ifidFlush    (ifidFlush),
    .memRead      (memRead),
    .missTimeout  (missTimeout),
    .inMiss       (inMiss)
`ifdef FETCH_PERF_CNT_EN
    ,
    .missCount    (missCount),
    .stallCycles  (stallCycles)
`endif
  );

  task automatic test_reset();
    Reset = 1'b1; hit = 1'b1; memReady = 1'b0; loadUseHazard = 1'b0; branchTaken = 1'b0;
    @(posedge Clk); #1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (obs !== 6'b011000) $display("FAIL reset_hold[%0d]: got %b want %b", i, obs, 6'b011000);
      else passed++;
      @(posedge Clk); #1;
    end
    Reset = 1'b0;
    #1;
    total++;
    if (obs !== 6'b110000) $display("FAIL reset_first_run: got %b want %b", obs, 6'b110000);
    else passed++;
`ifdef FETCH_PERF_CNT_EN
    total++;
    if (missCount !== 32'd0 || stallCycles !== 32'd0)
      $display("FAIL reset_counters: got %0d/%0d want 0/0", missCount, stallCycles);
    else passed++;
`endif
    @(posedge Clk); #1;
  endtask

  // Each vector is {hit, memReady, loadUseHazard, branchTaken, expected[5:0]}.
  task automatic test_miss();
    logic [9:0] v [5] = '{10'b0000_011100, 10'b1000_011110, 10'b1000_011110,
                          10'b1100_011110, 10'b1000_110000};
    for (int i = 0; i < 5; i++) begin
      {hit, memReady, loadUseHazard, branchTaken} = v[i][9:6];
      #1;
      total++;
      if (obs !== v[i][5:0]) $display("FAIL miss[%0d]: got %b want %b", i, obs, v[i][5:0]);
      else passed++;
      @(posedge Clk); #1;
    end
`ifdef FETCH_PERF_CNT_EN
    total++;
    if (missCount !== 32'd1) $display("FAIL miss_count: got %0d want 1", missCount);
    else passed++;
    total++;
    if (stallCycles !== 32'd4) $display("FAIL stall_cycles: got %0d want 4", stallCycles);
    else passed++;
`endif
  endtask

  task automatic test_branch_miss();
    logic [9:0] v [2] = '{10'b0001_111000, 10'b1000_110000};
    for (int i = 0; i < 2; i++) begin
      {hit, memReady, loadUseHazard, branchTaken} = v[i][9:6];
      #1;
      total++;
      if (obs !== v[i][5:0]) $display("FAIL branch_miss[%0d]: got %b want %b", i, obs, v[i][5:0]);
      else passed++;
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_load_use();
    logic [9:0] v [3] = '{10'b1010_000000, 10'b1010_000000, 10'b1000_110000};
    for (int i = 0; i < 3; i++) begin
      {hit, memReady, loadUseHazard, branchTaken} = v[i][9:6];
      #1;
      total++;
      if (obs !== v[i][5:0]) $display("FAIL load_use[%0d]: got %b want %b", i, obs, v[i][5:0]);
      else passed++;
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_timeout();
    logic [9:0] v [8] = '{10'b0000_011100, 10'b1000_011110, 10'b1010_001110,
                          10'b1000_011110, 10'b1000_011110, 10'b1000_110001,
                          10'b1000_110001, 10'b1001_111001};
    for (int i = 0; i < 8; i++) begin
      {hit, memReady, loadUseHazard, branchTaken} = v[i][9:6];
      #1;
      total++;
      if (obs !== v[i][5:0]) $display("FAIL timeout[%0d]: got %b want %b", i, obs, v[i][5:0]);
      else passed++;
      @(posedge Clk); #1;
    end
  endtask

  // Each vector is {Reset, hit, memReady, loadUseHazard, branchTaken, expected[5:0]}.
  task automatic test_reset_mid_miss();
    logic [10:0] v [6] = '{11'b00000_011101, 11'b01000_011111, 11'b11000_011001,
                           11'b11000_011000, 11'b01100_110000, 11'b01000_110000};
    for (int i = 0; i < 6; i++) begin
      {Reset, hit, memReady, loadUseHazard, branchTaken} = v[i][10:6];
      #1;
      total++;
      if (obs !== v[i][5:0]) $display("FAIL reset_mid_miss[%0d]: got %b want %b", i, obs, v[i][5:0]);
      else passed++;
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] v [5] = '{10'b0000_011100, 10'b1101_111110, 10'b0000_011100,
                          10'b1100_011110, 10'b1000_110000};
    for (int i = 0; i < 5; i++) begin
      {hit, memReady, loadUseHazard, branchTaken} = v[i][9:6];
      #1;
      total++;
      if (obs !== v[i][5:0]) $display("FAIL back_to_back[%0d]: got %b want %b", i, obs, v[i][5:0]);
      else passed++;
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_branch_during_miss();
    logic [9:0] v [6] = '{10'b0000_011100, 10'b1001_111110, 10'b1000_011110,
                          10'b1000_011110, 10'b1100_011110, 10'b1000_110000};
    for (int i = 0; i < 6; i++) begin
      {hit, memReady, loadUseHazard, branchTaken} = v[i][9:6];
      #1;
      total++;
      if (obs !== v[i][5:0]) $display("FAIL branch_during_miss[%0d]: got %b want %b", i, obs, v[i][5:0]);
      else passed++;
      @(posedge Clk); #1;
    end
`ifdef FETCH_PERF_CNT_EN
    total++;
    if (missCount !== 32'd3) $display("FAIL miss_count_final: got %0d want 3", missCount);
    else passed++;
    total++;
    if (stallCycles !== 32'd7) $display("FAIL stall_cycles_final: got %0d want 7", stallCycles);
    else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_miss();
    test_branch_miss();
    test_load_use();
    test_timeout();
    test_reset_mid_miss();
    test_back_to_back();
    test_branch_during_miss();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
